// File: rtl/vmac_stream.sv
// vmac_stream: VECTOR-lane signed fixed-point vector engine with MAC, MUL, ADD and per-lane ACC operations.
// Latency: 3 edges from the accepting edge to the registered result (S1 -> S2 -> S3/output); 1 beat/cycle.
// Backpressure: one global advance (adv) freezes every stage, including acc, while out_valid && !out_ready.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   in_valid / in_ready           input beat handshake; a_in, b_in, c_in, mode, lane_en, acc_clr travel with the beat
//   out_valid / out_ready         result beat handshake; o_out (packed lanes) and ovf (per-lane saturation flag)
//   Lane i of every packed bus occupies bits [I_WIDTH*i +: I_WIDTH].
module vmac_stream #(
    parameter int VECTOR  = 3,
    parameter int I_WIDTH = 16,
    parameter int FRAC    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [VECTOR*I_WIDTH-1:0] a_in,
    input  logic [VECTOR*I_WIDTH-1:0] b_in,
    input  logic [VECTOR*I_WIDTH-1:0] c_in,
    input  logic [1:0]                mode,
    input  logic [VECTOR-1:0]         lane_en,
    input  logic                      acc_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [VECTOR*I_WIDTH-1:0] o_out,
    output logic [VECTOR-1:0]         ovf
);

    localparam int PW = 2 * I_WIDTH;      // full product width
    localparam int RW = 2 * I_WIDTH + 1;  // pre-saturation result width

    typedef enum logic [1:0] {
        MODE_MAC = 2'b00,
        MODE_MUL = 2'b01,
        MODE_ADD = 2'b10,
        MODE_ACC = 2'b11
    } mode_e;

    // Per-beat control that rides alongside the operands through the pipe.
    typedef struct packed {
        mode_e             mode;
        logic [VECTOR-1:0] en;
        logic              clr;
    } ctl_t;

    typedef logic [VECTOR-1:0][I_WIDTH-1:0] lanes_t;
    typedef logic [VECTOR-1:0][PW-1:0]      prods_t;

    // Whole-pipe advance: the output slot is free or being drained this cycle.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // ------------------------------------------------------------------
    // S1: operand / control register
    // ------------------------------------------------------------------
    logic   s1_vld;
    lanes_t s1_a, s1_b, s1_c;
    ctl_t   s1_ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_a   <= a_in;
            s1_b   <= b_in;
            s1_c   <= c_in;
            s1_ctl <= {mode_e'(mode), lane_en, acc_clr};
        end
    end

    // Full signed product, then floor-shift back to the operand's fixed-point scale.
    prods_t s1_p;
    always_comb begin
        logic signed [PW-1:0] prod;
        prod = '0;
        s1_p = '0;
        for (int i = 0; i < VECTOR; i++) begin
            prod    = $signed(s1_a[i]) * $signed(s1_b[i]);
            s1_p[i] = prod >>> FRAC;
        end
    end

    // ------------------------------------------------------------------
    // S2: product register; a and c are carried for the ADD bypass and the add
    // ------------------------------------------------------------------
    logic   s2_vld;
    prods_t s2_p;
    lanes_t s2_a, s2_c;
    ctl_t   s2_ctl;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            s2_p   <= s1_p;
            s2_a   <= s1_a;
            s2_c   <= s1_c;
            s2_ctl <= s1_ctl;
        end
    end

    // ------------------------------------------------------------------
    // S3: add, saturate, lane masking. acc is read and written only here,
    // so consecutive ACC beats chain through it at full rate.
    // ------------------------------------------------------------------
    lanes_t            acc;
    lanes_t            s3_res;
    logic [VECTOR-1:0] s3_ovf;

    always_comb begin
        logic [RW-1:0] r, pe, ae, ce, acce;
        logic          fits;
        r      = '0;
        pe     = '0;
        ae     = '0;
        ce     = '0;
        acce   = '0;
        fits   = 1'b1;
        s3_res = '0;
        s3_ovf = '0;
        for (int i = 0; i < VECTOR; i++) begin
            pe   = {s2_p[i][PW-1], s2_p[i]};
            ae   = {{(RW-I_WIDTH){s2_a[i][I_WIDTH-1]}}, s2_a[i]};
            ce   = {{(RW-I_WIDTH){s2_c[i][I_WIDTH-1]}}, s2_c[i]};
            acce = {{(RW-I_WIDTH){acc[i][I_WIDTH-1]}}, acc[i]};
            r    = '0;
            case (s2_ctl.mode)
                MODE_MAC: r = pe + ce;
                MODE_MUL: r = pe;
                MODE_ADD: r = ae + ce;
                MODE_ACC: r = s2_ctl.clr ? pe : acce + pe;
            endcase
            // r fits in I_WIDTH bits when everything from the lane's sign bit up is a sign extension.
            fits = (&r[RW-1:I_WIDTH-1]) || !(|r[RW-1:I_WIDTH-1]);
            if (s2_ctl.en[i]) begin
                s3_res[i] = fits ? r[I_WIDTH-1:0] : {r[RW-1], {(I_WIDTH-1){~r[RW-1]}}};
                s3_ovf[i] = !fits;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o_out     <= '0;
            ovf       <= '0;
            acc       <= '0;
        end else if (adv) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                o_out <= s3_res;
                ovf   <= s3_ovf;
                if (s2_ctl.mode == MODE_ACC) begin
                    for (int i = 0; i < VECTOR; i++) begin
                        if (s2_ctl.en[i]) acc[i] <= s3_res[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vmac_stream.sv
`timescale 1ns/1ps
module tb_vmac_stream;

    localparam int V  = 3;
    localparam int W  = 16;
    localparam int F  = 8;
    localparam int VW = V * W;
    localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (W - 1));

    typedef logic [V+VW-1:0] beat_t;  // {ovf, o_out}

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] a_in = '0, b_in = '0, c_in = '0;
    logic [1:0]    mode = 2'b00;
    logic [V-1:0]  lane_en = '1;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] o_out;
    logic [V-1:0]  ovf;

    always #5 clk = ~clk;

    vmac_stream #(.VECTOR(V), .I_WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .mode(mode), .lane_en(lane_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_out(o_out), .ovf(ovf)
    );

    int     errors = 0;
    int     checks = 0;
    beat_t  exp_q[$];
    beat_t  got_q[$];
    longint macc[V];
    int     rdy_mode = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: random
    int     rdy_cnt = 0;
    bit     drv_timeout = 1'b0;

    // Result sink: out_ready changes 1 ns after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_cnt++;
            case (rdy_mode)
                1:       out_ready = (rdy_cnt % 3 == 0);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Record every beat the sink takes (the handshake completes at the following edge).
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back({ovf, o_out});
    end

    // Reference: per-lane arithmetic straight from the operation rules, in 64-bit integers.
    task automatic model_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c,
                              input logic [1:0] m, input logic [V-1:0] en, input logic clr);
        logic [VW-1:0] o;
        logic [V-1:0]  f;
        o = '0;
        f = '0;
        for (int i = 0; i < V; i++) begin
            longint av, bv, cv, p, r;
            logic   sat;
            av  = $signed(a[i*W +: W]);
            bv  = $signed(b[i*W +: W]);
            cv  = $signed(c[i*W +: W]);
            p   = (av * bv) >>> F;
            case (m)
                2'b00:   r = p + cv;
                2'b01:   r = p;
                2'b10:   r = av + cv;
                default: r = clr ? p : macc[i] + p;
            endcase
            sat = 1'b0;
            if (r > MAXV) begin r = MAXV; sat = 1'b1; end
            else if (r < MINV) begin r = MINV; sat = 1'b1; end
            if (en[i]) begin
                o[i*W +: W] = r[W-1:0];
                f[i]        = sat;
                if (m == 2'b11) macc[i] = r;
            end
        end
        exp_q.push_back({f, o});
    endtask

    // Present one beat starting at posedge+1 and hold it until accepted; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c,
                             input logic [1:0] m, input logic [V-1:0] en, input logic clr);
        bit done;
        done     = 1'b0;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        mode     = m;
        lane_en  = en;
        acc_clr  = clr;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            #2;
            if (in_ready === 1'b1) begin
                model_beat(a, b, c, m, en, clr);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) drv_timeout = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 400 && got_q.size() < n; t++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        int            s;
        v = '0;
        for (int i = 0; i < V; i++) begin
            if ($urandom_range(0, 3) == 0) s = int'($urandom);
            else                           s = int'($urandom_range(0, 2047)) - 1024;
            v[i*W +: W] = s[W-1:0];
        end
        return v;
    endfunction

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (o_out !== '0) begin errors++; $display("FAIL reset_o_out: got %h want 0", o_out); end
        checks++; if (ovf !== '0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid: got %b want 0", out_valid); end
        for (int i = 0; i < V; i++) macc[i] = 0;
        clear_queues();
    endtask

    task automatic test_basic_mac();
        a_in     = {V{16'h0200}};
        b_in     = {V{16'h0180}};
        c_in     = {V{16'h0100}};
        mode     = 2'b00;
        lane_en  = '1;
        acc_clr  = 1'b0;
        in_valid = 1'b1;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mac_accept_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;  // accepting edge
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            checks++;
            if (out_valid !== (e == 3)) begin
                errors++; $display("FAIL mac_latency edge %0d: out_valid %b want %b", e, out_valid, (e == 3));
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mac_in_ready edge %0d: got %b want 1", e, in_ready); end
            if (e < 3) begin @(posedge clk); #1; end
        end
        checks++; if (o_out[15:0] !== 16'h0400) begin errors++; $display("FAIL mac_lane0: got %h want 0400", o_out[15:0]); end
        checks++; if (o_out !== {V{16'h0400}}) begin errors++; $display("FAIL mac_all_lanes: got %h want %h", o_out, {V{16'h0400}}); end
        checks++; if (ovf !== '0) begin errors++; $display("FAIL mac_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mac_drain: out_valid %b want 0", out_valid); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mac_count: got %0d beats want 1", got_q.size()); end
        clear_queues();
    endtask

    task automatic test_saturation();
        beat_t want[3];
        want[0] = {3'b001, 16'h0000, 16'h0000, 16'h7FFF};
        want[1] = {3'b000, 16'h0000, 16'hFF00, 16'h0000};
        want[2] = {3'b100, 16'h8000, 16'h0000, 16'h0000};
        send_beat({16'h0000, 16'h0000, 16'h7F00}, {16'h0000, 16'h0000, 16'h7F00}, '0, 2'b01, '1, 1'b0);
        send_beat({16'h0000, 16'hFF00, 16'h0000}, {16'h0000, 16'h0100, 16'h0000}, '0, 2'b00, '1, 1'b0);
        send_beat({16'h8000, 16'h0000, 16'h0000}, '0, {16'hFF00, 16'h0000, 16'h0000}, 2'b10, '1, 1'b0);
        wait_got(3);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL sat_count: got %0d beats want 3", got_q.size()); end
        for (int k = 0; k < 3 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== want[k]) begin errors++; $display("FAIL sat_beat%0d: got %h want %h", k, got_q[k], want[k]); end
        end
        clear_queues();
    endtask

    task automatic test_accumulate();
        logic [15:0] wv[5];
        wv[0] = 16'h0080; wv[1] = 16'h0100; wv[2] = 16'h0180; wv[3] = 16'h0200; wv[4] = 16'h0080;
        for (int k = 0; k < 5; k++)
            send_beat({V{16'h0100}}, {V{16'h0080}}, '0, 2'b11, '1, (k == 0 || k == 4));
        wait_got(5);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL acc_count: got %0d beats want 5", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== {3'b000, {V{wv[k]}}}) begin
                errors++; $display("FAIL acc_beat%0d: got %h want %h", k, got_q[k], {3'b000, {V{wv[k]}}});
            end
        end
        clear_queues();
    endtask

    task automatic test_lane_disable();
        beat_t want[4];
        want[0] = {3'b000, 16'h0100, 16'h0100, 16'h0100};
        want[1] = {3'b000, 16'h0000, 16'h0200, 16'h0000};
        want[2] = {3'b000, 16'h0000, 16'h0400, 16'h0000};
        want[3] = {3'b000, 16'h0200, 16'h0500, 16'h0200};
        send_beat({V{16'h0100}}, {V{16'h0100}}, '0, 2'b11, 3'b111, 1'b1);
        send_beat({V{16'h0100}}, {V{16'h0100}}, '0, 2'b11, 3'b010, 1'b0);
        send_beat({V{16'h0200}}, {V{16'h0200}}, '0, 2'b11, 3'b010, 1'b1);
        send_beat({V{16'h0100}}, {V{16'h0100}}, '0, 2'b11, 3'b111, 1'b0);
        wait_got(4);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL lane_count: got %0d beats want 4", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== want[k]) begin errors++; $display("FAIL lane_beat%0d: got %h want %h", k, got_q[k], want[k]); end
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        logic  prev_stall;
        beat_t held_b;
        logic  held_v;
        prev_stall = 1'b0;
        held_b     = '0;
        held_v     = 1'b0;
        rdy_mode   = 1;
        fork
            begin
                for (int k = 0; k < 6; k++) send_beat(rnd_vec(), rnd_vec(), rnd_vec(), 2'b00, '1, 1'b0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        checks++;
                        if (in_ready !== out_ready) begin
                            errors++; $display("FAIL bp_in_ready: in_ready %b want out_ready %b", in_ready, out_ready);
                        end
                    end
                    if (prev_stall) begin
                        checks++;
                        if ({out_valid, ovf, o_out} !== {held_v, held_b}) begin
                            errors++; $display("FAIL bp_stall_hold: got %b/%h want %b/%h", out_valid, {ovf, o_out}, held_v, held_b);
                        end
                    end
                    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
                    held_v     = out_valid;
                    held_b     = {ovf, o_out};
                end
            end
        join
        rdy_mode = 0;
        wait_got(6);
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d beats want 6", got_q.size()); end
        for (int k = 0; k < 6 && k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        clear_queues();
    endtask

    task automatic test_random();
        int n;
        n        = 150;
        rdy_mode = 2;
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            send_beat(rnd_vec(), rnd_vec(), rnd_vec(), 2'($urandom_range(0, 3)), V'($urandom),
                      ($urandom_range(0, 3) == 0));
        end
        rdy_mode = 0;
        wait_got(n);
        checks++; if (got_q.size() != n) begin errors++; $display("FAIL rand_count: got %0d beats want %0d", got_q.size(), n); end
        for (int k = 0; k < n && k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_beat%0d: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        clear_queues();
    endtask

    task automatic test_reset_midstream();
        rdy_mode = 0;
        send_beat({V{16'h0100}}, {V{16'h0100}}, '0, 2'b11, '1, 1'b1);  // acc = 0x0100 on every lane
        wait_got(1);
        clear_queues();
        for (int k = 0; k < 3; k++) send_beat(rnd_vec(), rnd_vec(), rnd_vec(), 2'b11, '1, 1'b0);
        rst = 1'b1;  // three beats now sit in S1, S2 and the output register
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (o_out !== '0) begin errors++; $display("FAIL mid_rst_o_out: got %h want 0", o_out); end
        checks++; if (ovf !== '0) begin errors++; $display("FAIL mid_rst_ovf: got %b want 0", ovf); end
        for (int i = 0; i < V; i++) macc[i] = 0;
        exp_q.delete();
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_rst_stale: got %0d beats want 0", got_q.size()); end
        send_beat({V{16'h0100}}, {V{16'h0100}}, '0, 2'b11, '1, 1'b0);
        wait_got(1);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL mid_rst_count: got %0d beats want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== {3'b000, {V{16'h0100}}}) begin
                errors++; $display("FAIL mid_rst_acc: got %h want %h", got_q[0], {3'b000, {V{16'h0100}}});
            end
        end
        clear_queues();
        checks++; if (drv_timeout) begin errors++; $display("FAIL driver_timeout: a beat was never accepted"); end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic_mac();
        test_saturation();
        test_accumulate();
        test_lane_disable();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
